// File: rtl/soc_data_bus.sv
// SCPU data-port decoder: passes RAM accesses to data_memory and hosts the
// MMIO block (LED latch, compare/IRQ timer, byte TX FIFO for a UART).
module soc_data_bus #(
  parameter int unsigned TX_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_we,
  output logic [31:0] cpu_rdata,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata,
  output logic [15:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);
  localparam int unsigned PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);

  logic [15:0]   r_led;
  logic [31:0]   r_tcount;
  logic [31:0]   r_tcmp;
  logic          r_t_en;
  logic          r_t_flag;
  logic          r_t_reload;
  logic          r_t_ien;
  logic [7:0]    r_fifo [TX_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_is_ram;
  logic          w_is_mmio;
  logic [3:0]    w_word;
  logic          w_wr;
  logic          w_wr_led;
  logic          w_wr_tcount;
  logic          w_wr_tcmp;
  logic          w_wr_tctrl;
  logic          w_wr_txstat;
  logic          w_push_req;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_t_set;
  logic [3:0]    w_cnt4;
  logic [31:0]   w_txstat;
  logic [31:0]   w_mmio_rdata;
  logic          w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

  assign w_is_ram  = (cpu_addr[31:12] == 20'd0);
  assign w_is_mmio = (cpu_addr[31:6] == MMIO_BASE[31:6]);
  assign w_word    = cpu_addr[5:2];
  assign w_wr      = w_is_mmio && (|cpu_we);
  assign w_unused  = &{1'b0, cpu_addr[1:0]};

  assign w_wr_led    = w_wr && (w_word == 4'd0);
  assign w_wr_tcount = w_wr && (w_word == 4'd1);
  assign w_wr_tcmp   = w_wr && (w_word == 4'd2);
  assign w_wr_tctrl  = w_wr && (w_word == 4'd3) && cpu_we[0];
  assign w_push_req  = w_wr && (w_word == 4'd4) && cpu_we[0];
  assign w_wr_txstat = w_wr && (w_word == 4'd5) && cpu_we[0];

  // Data path to data_memory is purely combinational and never gated by rst.
  assign mem_addr  = cpu_addr[11:2];
  assign mem_wdata = cpu_wdata;
  assign mem_we    = w_is_ram ? cpu_we : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= '0;
    end else if (w_wr_led) begin
      r_led[7:0]  <= cpu_we[0] ? cpu_wdata[7:0]  : r_led[7:0];
      r_led[15:8] <= cpu_we[1] ? cpu_wdata[15:8] : r_led[15:8];
    end
  end

  // A CPU load of TCOUNT suppresses both the count step and the compare event.
  assign w_t_set = r_t_en && (r_tcount == r_tcmp) && !w_wr_tcount;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcount   <= '0;
      r_tcmp     <= 32'hFFFF_FFFF;
      r_t_en     <= 1'b0;
      r_t_flag   <= 1'b0;
      r_t_reload <= 1'b0;
      r_t_ien    <= 1'b0;
    end else begin
      if (w_wr_tcount)
        r_tcount <= f_merge(r_tcount, cpu_wdata, cpu_we);
      else if (w_t_set)
        r_tcount <= r_t_reload ? 32'd0 : r_tcount + 32'd1;
      else if (r_t_en)
        r_tcount <= r_tcount + 32'd1;
      if (w_wr_tcmp)
        r_tcmp <= f_merge(r_tcmp, cpu_wdata, cpu_we);
      if (w_wr_tctrl) begin
        r_t_en     <= cpu_wdata[0];
        r_t_reload <= cpu_wdata[2];
        r_t_ien    <= cpu_wdata[3];
      end
      if (w_t_set)
        r_t_flag <= 1'b1;
      else if (w_wr_tctrl && cpu_wdata[1])
        r_t_flag <= 1'b0;
    end
  end

  assign timer_irq = r_t_flag && r_t_ien;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = tx_valid && tx_ready;
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wr_ptr] <= cpu_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)
        r_ovf <= 1'b1;
      else if (w_wr_txstat && cpu_wdata[2])
        r_ovf <= 1'b0;
    end
  end

  assign tx_valid = !w_empty;
  assign tx_data  = r_fifo[r_rd_ptr];
  assign led      = r_led;

  assign w_cnt4   = 4'(r_count);
  assign w_txstat = {24'd0, w_cnt4, 1'b0, r_ovf, w_empty, w_full};

  always_comb begin
    w_mmio_rdata = '0;
    case (w_word)
      4'd0:    w_mmio_rdata = {16'd0, r_led};
      4'd1:    w_mmio_rdata = r_tcount;
      4'd2:    w_mmio_rdata = r_tcmp;
      4'd3:    w_mmio_rdata = {28'd0, r_t_ien, r_t_reload, r_t_flag, r_t_en};
      4'd5:    w_mmio_rdata = w_txstat;
      default: w_mmio_rdata = '0;
    endcase
  end

  assign cpu_rdata = w_is_ram  ? mem_rdata :
                     w_is_mmio ? w_mmio_rdata : 32'd0;

endmodule

// File: tb/tb_soc_data_bus.sv
// Self-checking bench for soc_data_bus: directed scenarios with a byte
// scoreboard on the TX drain port.
module tb_soc_data_bus;
  localparam logic [31:0] A_LED    = 32'hFFFF_0000;
  localparam logic [31:0] A_TCOUNT = 32'hFFFF_0004;
  localparam logic [31:0] A_TCMP   = 32'hFFFF_0008;
  localparam logic [31:0] A_TCTRL  = 32'hFFFF_000C;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0010;
  localparam logic [31:0] A_TXSTAT = 32'hFFFF_0014;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;
  logic [15:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  logic [7:0] exp_q[$];
  int pass_cnt = 0;
  int chk_cnt  = 0;

  soc_data_bus #(.TX_DEPTH(4), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .led(led), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .timer_irq(timer_irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] we);
    @(negedge clk);
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_we    = we;
    @(posedge clk);
    #1;
    cpu_we = 4'b0000;
  endtask

  task automatic cpu_read(input logic [31:0] addr, output logic [31:0] data);
    cpu_addr = addr;
    cpu_we   = 4'b0000;
    #1;
    data = cpu_rdata;
  endtask

  task automatic push_byte(input logic [7:0] b);
    cpu_write(A_TXDATA, {24'd0, b}, 4'b0001);
    if (exp_q.size() < 4) exp_q.push_back(b);
  endtask

  task automatic drain(input int max_cycles);
    tx_ready = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (tx_valid) begin
        chk_cnt++;
        if (exp_q.size() == 0)
          $display("FAIL drain_extra: got byte %h, expected none", tx_data);
        else if (tx_data !== exp_q[0])
          $display("FAIL drain_order: got %h, expected %h", tx_data, exp_q[0]);
        else pass_cnt++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        break;
      end
    end
    tx_ready = 1'b0;
    chk_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL drain_timeout: %0d bytes left, expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = '0;
    mem_rdata = '0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b, expected 0", tx_valid); else pass_cnt++;
    chk_cnt++; if (timer_irq !== 1'b0) $display("FAIL rst_irq: got %b, expected 0", timer_irq); else pass_cnt++;
    chk_cnt++; if (led !== 16'h0) $display("FAIL rst_led: got %h, expected 0", led); else pass_cnt++;
    cpu_read(A_TCMP, rd);
    chk_cnt++; if (rd !== 32'hFFFF_FFFF) $display("FAIL rst_tcmp: got %h, expected ffffffff", rd); else pass_cnt++;
    cpu_read(A_TCOUNT, rd);
    chk_cnt++; if (rd !== 32'h0) $display("FAIL rst_tcount: got %h, expected 0", rd); else pass_cnt++;
    cpu_read(A_TCTRL, rd);
    chk_cnt++; if (rd !== 32'h0) $display("FAIL rst_tctrl: got %h, expected 0", rd); else pass_cnt++;
    cpu_read(A_TXSTAT, rd);
    chk_cnt++; if (rd !== 32'h2) $display("FAIL rst_txstat: got %h, expected 2", rd); else pass_cnt++;
  endtask

  task automatic test_ram;
    logic [31:0] rv;
    logic [31:0] a;
    @(posedge clk); #1;
    cpu_addr = 32'h0000_0010; cpu_wdata = 32'hDEAD_BEEF; cpu_we = 4'hF; #1;
    chk_cnt++; if (mem_we !== 4'hF) $display("FAIL ram_we: got %h, expected f", mem_we); else pass_cnt++;
    chk_cnt++; if (mem_addr !== 10'd4) $display("FAIL ram_addr: got %h, expected 4", mem_addr); else pass_cnt++;
    chk_cnt++; if (mem_wdata !== 32'hDEAD_BEEF) $display("FAIL ram_wdata: got %h, expected deadbeef", mem_wdata); else pass_cnt++;
    rv = $urandom; mem_rdata = rv; cpu_we = 4'h0; #1;
    chk_cnt++; if (cpu_rdata !== rv) $display("FAIL ram_rdata: got %h, expected %h", cpu_rdata, rv); else pass_cnt++;
    cpu_addr = 32'h8000_0000; cpu_we = 4'hF; #1;
    chk_cnt++; if (mem_we !== 4'h0) $display("FAIL unmapped_we: got %h, expected 0", mem_we); else pass_cnt++;
    chk_cnt++; if (cpu_rdata !== 32'h0) $display("FAIL unmapped_rdata: got %h, expected 0", cpu_rdata); else pass_cnt++;
    cpu_addr = A_LED; cpu_we = 4'h0; cpu_addr = 32'hFFFF_0020; #1;
    chk_cnt++; if (cpu_rdata !== 32'h0) $display("FAIL mmio_hole_rdata: got %h, expected 0", cpu_rdata); else pass_cnt++;
    cpu_we = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      a = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      cpu_addr = a; cpu_we = 4'($urandom_range(1, 15)); #1;
      chk_cnt++; if (mem_addr !== a[11:2] || mem_we !== cpu_we) $display("FAIL ram_rand: addr %h we %h, expected %h %h", mem_addr, mem_we, a[11:2], cpu_we); else pass_cnt++;
      cpu_we = 4'h0;
    end
    mem_rdata = '0;
  endtask

  task automatic test_led;
    logic [31:0] rd;
    cpu_write(A_LED, 32'h0000_A5C3, 4'b0001);
    chk_cnt++; if (led !== 16'h00C3) $display("FAIL led_be0: got %h, expected 00c3", led); else pass_cnt++;
    cpu_write(A_LED, 32'h0000_A5C3, 4'b0011);
    chk_cnt++; if (led !== 16'hA5C3) $display("FAIL led_be01: got %h, expected a5c3", led); else pass_cnt++;
    cpu_read(A_LED, rd);
    chk_cnt++; if (rd !== 32'h0000_A5C3) $display("FAIL led_read: got %h, expected 0000a5c3", rd); else pass_cnt++;
  endtask

  task automatic test_timer;
    logic [31:0] rd;
    cpu_write(A_TCOUNT, 32'd0, 4'hF);
    cpu_write(A_TCMP, 32'd5, 4'hF);
    cpu_write(A_TCTRL, 32'hD, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    cpu_read(A_TCOUNT, rd);
    chk_cnt++; if (rd !== 32'd5) $display("FAIL timer_at_cmp: got %0d, expected 5", rd); else pass_cnt++;
    chk_cnt++; if (timer_irq !== 1'b0) $display("FAIL timer_irq_early: got %b, expected 0", timer_irq); else pass_cnt++;
    @(posedge clk); #1;
    cpu_read(A_TCOUNT, rd);
    chk_cnt++; if (rd !== 32'd0) $display("FAIL timer_reload: got %0d, expected 0", rd); else pass_cnt++;
    chk_cnt++; if (timer_irq !== 1'b1) $display("FAIL timer_irq_set: got %b, expected 1", timer_irq); else pass_cnt++;
    cpu_read(A_TCTRL, rd);
    chk_cnt++; if (rd !== 32'hF) $display("FAIL tctrl_flag: got %h, expected f", rd); else pass_cnt++;
    cpu_write(A_TCTRL, 32'hF, 4'hF);
    chk_cnt++; if (timer_irq !== 1'b0) $display("FAIL timer_irq_clear: got %b, expected 0", timer_irq); else pass_cnt++;
    cpu_read(A_TCTRL, rd);
    chk_cnt++; if (rd !== 32'hD) $display("FAIL tctrl_after_clear: got %h, expected d", rd); else pass_cnt++;
    cpu_read(A_TCOUNT, rd);
    chk_cnt++; if (rd !== 32'd1) $display("FAIL timer_running: got %0d, expected 1", rd); else pass_cnt++;
    cpu_write(A_TCTRL, 32'h0, 4'hF);
  endtask

  task automatic test_timer_priority;
    logic [31:0] rd;
    cpu_write(A_TCMP, 32'hFFFF_FFFF, 4'hF);
    cpu_write(A_TCTRL, 32'h1, 4'hF);
    repeat (3) @(posedge clk);
    cpu_write(A_TCOUNT, 32'd100, 4'hF);
    cpu_read(A_TCOUNT, rd);
    chk_cnt++; if (rd !== 32'd100) $display("FAIL tcount_load: got %0d, expected 100", rd); else pass_cnt++;
    @(posedge clk); #1;
    cpu_read(A_TCOUNT, rd);
    chk_cnt++; if (rd !== 32'd101) $display("FAIL tcount_inc: got %0d, expected 101", rd); else pass_cnt++;
    cpu_write(A_TCTRL, 32'h0, 4'hF);
  endtask

  task automatic test_fifo_overflow;
    logic [31:0] rd;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_byte(8'h41 + 8'(i));
      cpu_read(A_TXSTAT, rd);
      if (i == 3) begin
        chk_cnt++; if (rd !== 32'h41) $display("FAIL txstat_full: got %h, expected 41", rd); else pass_cnt++;
      end
      if (i == 4) begin
        chk_cnt++; if (rd !== 32'h45) $display("FAIL txstat_ovf: got %h, expected 45", rd); else pass_cnt++;
      end
    end
    drain(20);
    chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL drained_valid: got %b, expected 0", tx_valid); else pass_cnt++;
    cpu_read(A_TXSTAT, rd);
    chk_cnt++; if (rd !== 32'h6) $display("FAIL txstat_empty_ovf: got %h, expected 6", rd); else pass_cnt++;
    cpu_write(A_TXSTAT, 32'h4, 4'h1);
    cpu_read(A_TXSTAT, rd);
    chk_cnt++; if (rd !== 32'h2) $display("FAIL txstat_ovf_clear: got %h, expected 2", rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) push_byte(8'h61 + 8'(i));
    @(negedge clk);
    tx_ready = 1'b1; cpu_addr = A_TXDATA; cpu_wdata = 32'h55; cpu_we = 4'b0001;
    chk_cnt++;
    if (!tx_valid || exp_q.size() == 0 || tx_data !== exp_q[0])
      $display("FAIL full_pop_head: got %h valid %b, expected 61", tx_data, tx_valid);
    else pass_cnt++;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    @(posedge clk); #1;
    cpu_we = 4'b0000; tx_ready = 1'b0;
    cpu_read(A_TXSTAT, rd);
    chk_cnt++; if (rd !== 32'h41) $display("FAIL full_push_pop_stat: got %h, expected 41", rd); else pass_cnt++;
    drain(20);
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    cpu_write(A_TCMP, 32'h10, 4'hF);
    cpu_write(A_TCOUNT, 32'h10, 4'hF);
    cpu_write(A_TCTRL, 32'h9, 4'hF);
    @(posedge clk); #1;
    chk_cnt++; if (timer_irq !== 1'b1) $display("FAIL pre_rst_irq: got %b, expected 1", timer_irq); else pass_cnt++;
    for (int i = 0; i < 3; i++) push_byte(8'h71 + 8'(i));
    @(negedge clk);
    tx_ready = 1'b1;
    chk_cnt++; if (tx_data !== exp_q[0]) $display("FAIL mid_drain_head: got %h, expected %h", tx_data, exp_q[0]); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    chk_cnt++; if (tx_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b, expected 0", tx_valid); else pass_cnt++;
    chk_cnt++; if (timer_irq !== 1'b0) $display("FAIL mid_rst_irq: got %b, expected 0", timer_irq); else pass_cnt++;
    cpu_read(A_TXSTAT, rd);
    chk_cnt++; if (rd !== 32'h2) $display("FAIL mid_rst_txstat: got %h, expected 2", rd); else pass_cnt++;
    cpu_read(A_TCTRL, rd);
    chk_cnt++; if (rd !== 32'h0) $display("FAIL mid_rst_tctrl: got %h, expected 0", rd); else pass_cnt++;
    chk_cnt++; if (led !== 16'h0) $display("FAIL mid_rst_led: got %h, expected 0", led); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; tx_ready = 1'b0;
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_ram();
    test_led();
    test_timer();
    test_timer_priority();
    test_fifo_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
